mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between two requesters: port 0 is instruction fetch, port 1 is the mem stage (loads, stores and atomics).
- Each requester port uses the same request/response signal set as the bus itself. Requests are captured, arbitrated round-robin and issued one at a time.
- Responses are routed back to the requester that issued the transaction.
- Sits between the core stages and the memory/bus adapter. Provides a bounded-wait timeout so a lost response cannot hang the core.

Parameters:
- TIMEOUT, 1024, BUSY cycles without a response before a forced error completion; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- p_request_enable  in  2  per-port one-cycle request pulse; index 0 = fetch, 1 = mem
- p_mode  in  2  per-port MEMREQ_READ/MEMREQ_WRITE
- p_addr  in  2x32  per-port address
- p_wdata  in  2x32  per-port write data
- p_wstrb  in  2x4  per-port byte strobes
- p_response_enable  out  2  per-port one-cycle completion pulse
- p_data  out  32  read data, shared; valid only with p_response_enable
- p_error  out  2  per-port pulse, coincident with p_response_enable, marks a timeout completion
- request_enable  out  1  bus request pulse
- mode  out  1  bus mode
- addr  out  32  bus address
- wdata  out  32  bus write data
- wstrb  out  4  bus byte strobes
- response_enable  in  1  bus completion pulse
- data  in  32  bus read data
- overflow  out  1  sticky flag: a request arrived while the same port was already pending or in flight

Behaviour:
- All outputs are registered.
- Reset values:
  - All pulse outputs 0; addr, wdata and p_data 0; wstrb 0; mode MEMREQ_READ; overflow 0.
  - State IDLE, pend 2'b00, last_grant 1 (so port 0 wins the first tie), timeout counter 0.
- Capture:
  - A p_request_enable[i] pulse loads a per-port holding register (mode/addr/wdata/wstrb) and sets pend[i].
  - One holding slot per port.
  - A new pulse while pend[i] is set, or while port i is in flight, is dropped and sets overflow. overflow is cleared only by rst.
- States: IDLE, BUSY.
- IDLE, at each edge:
  - Candidates are pend[i] OR p_request_enable[i] in the same cycle; an incoming request bypasses the holding register.
  - If both ports are candidates, the winner is ~last_grant; otherwise the single candidate wins.
  - On a grant:
    - Drive the winner's fields onto the bus and pulse request_enable for exactly 1 cycle.
    - Clear the winner's pend bit; keep the loser's pend bit set.
    - Record grant = winner; go to BUSY; zero the counter.
  - Minimum latency: request pulse at edge k gives request_enable high in the cycle after edge k.
- BUSY:
  - request_enable is 0. Bus fields hold their values until the next grant.
  - The counter increments each cycle.
  - When response_enable is high at edge k:
    - p_response_enable[grant] = 1 and p_data = data in the following cycle.
    - last_grant = grant; state goes to IDLE.
    - The next grant can occur at edge k+1, giving back-to-back traffic with one idle bus cycle.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without a response:
    - p_response_enable[grant] = 1, p_error[grant] = 1, p_data = 0; go to IDLE.
    - A late bus response arriving afterwards in IDLE is ignored.
- Simultaneous events:
  - Response for port i and a new request from port i on the same edge: the new request is captured (not an overflow, since in-flight ends on that edge) and may be granted the next edge.
  - Requests from both ports on the same edge: one wins, the other is pended with no loss.
- response_enable while IDLE is ignored.
- Reset mid-transaction: everything returns to reset values. Pending requests are discarded and no response is delivered to either port.

Decomposition:
- Shared package (def.sv):
  - MEMREQ_READ/MEMREQ_WRITE (already present).
  - New typedef memreq_t {mode, addr[31:0], wdata[31:0], wstrb[3:0]} used for the holding registers and the bus drive.
  - Arbiter state enum.
- One natural sub-module: mem_req_slot, the per-port holding register with pend bit, capture, overflow detect and clear-on-grant. It is instantiated twice.

Test Plan:
- Single read: port 0 requests addr 0x100 at edge 1; bus response_enable at edge 5 with data 0xDEADBEEF -> request_enable pulsed one cycle with addr 0x100 and mode READ; p_response_enable[0] high one cycle with p_data 0xDEADBEEF; p_response_enable[1] stays 0.
- Tie after reset: both ports request on the same edge (port 1: write, addr 0x200, wdata 0x11223344, wstrb 4'b1111) -> port 0 issued first; port 1 issued the edge after port 0's response, with its fields intact; a second tie is then won by port 0 again (last_grant = 1).
- Round-robin: port 1 holds continuous traffic while port 0 requests -> grants alternate 0,1,0,1; neither port waits more than one transaction.
- Same-edge respond/request: port 1's response and port 1's new request (addr 0x204) on the same edge -> no overflow; 0x204 issued at the next edge.
- Overflow: port 1 requests twice while its first request is in flight -> overflow = 1 and stays 1; only one request_enable is issued for port 1.
- Timeout with TIMEOUT=8: no response after a grant -> p_response_enable and p_error pulse together 8 cycles after the grant with p_data 0; a bus response at cycle 12 is ignored. Reset asserted during BUSY -> all outputs return to reset values and a subsequent response_enable produces no port response.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: request encoding,
// the holding/bus request record and the arbiter state.
package mem_bus_arbiter_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memreq_t;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep holding register for a requester port: captures a request that
// cannot be issued immediately and flags pulses that arrive with no room.
module mem_req_slot
    import mem_bus_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req,
    input  memreq_t incoming,
    input  logic    busy,
    input  logic    take,
    output logic    pend,
    output memreq_t slot_req,
    output logic    ovf
);

    memreq_t held;
    logic    accept;

    // A request taken on its arrival edge bypasses the holding register.
    always_comb begin
        accept   = req && !pend && !busy;
        ovf      = req && (pend || busy);
        slot_req = pend ? held : incoming;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            held <= '0;
        end else begin
            if (accept) held <= incoming;
            if (take)
                pend <= 1'b0;
            else if (accept)
                pend <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch
// (port 0) and the mem stage (port 1), with a bounded response timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       p_request_enable,
    input  logic [1:0]       p_mode,
    input  logic [1:0][31:0] p_addr,
    input  logic [1:0][31:0] p_wdata,
    input  logic [1:0][3:0]  p_wstrb,
    output logic [1:0]       p_response_enable,
    output logic [31:0]      p_data,
    output logic [1:0]       p_error,
    output logic             request_enable,
    output logic             mode,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    input  logic             response_enable,
    input  logic [31:0]      data,
    output logic             overflow
);

    arb_state_t       state;
    logic             grant;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    memreq_t          bus;

    logic [1:0] pend;
    logic [1:0] busy;
    logic [1:0] take;
    logic [1:0] ovf;
    logic [1:0] cand;
    logic       winner;
    logic       timed_out;
    logic       done;
    memreq_t    incoming [2];
    memreq_t    slot_req [2];

    assign mode  = bus.mode;
    assign addr  = bus.addr;
    assign wdata = bus.wdata;
    assign wstrb = bus.wstrb;

    // The in-flight port is released on the completing edge, so a same-edge
    // re-request from it is captured rather than counted as an overflow.
    always_comb begin
        timed_out = (TIMEOUT != 0) && (state == BUSY) && !response_enable &&
                    (cnt == CNT_W'(TIMEOUT - 1));
        done      = (state == BUSY) && (response_enable || timed_out);
        cand      = pend | p_request_enable;
        winner    = (&cand) ? ~last_grant : cand[1];
        take      = '0;
        if (state == IDLE && |cand) take[winner] = 1'b1;
        busy      = '0;
        if (state == BUSY && !done) busy[grant] = 1'b1;
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        assign incoming[i] = '{mode: p_mode[i], addr: p_addr[i],
                               wdata: p_wdata[i], wstrb: p_wstrb[i]};

        mem_req_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .req      (p_request_enable[i]),
            .incoming (incoming[i]),
            .busy     (busy[i]),
            .take     (take[i]),
            .pend     (pend[i]),
            .slot_req (slot_req[i]),
            .ovf      (ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            grant             <= 1'b0;
            last_grant        <= 1'b1;
            cnt               <= '0;
            bus               <= '0;
            request_enable    <= 1'b0;
            p_response_enable <= '0;
            p_error           <= '0;
            p_data            <= '0;
            overflow          <= 1'b0;
        end else begin
            request_enable    <= 1'b0;
            p_response_enable <= '0;
            p_error           <= '0;
            if (|ovf) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (|cand) begin
                        bus            <= slot_req[winner];
                        request_enable <= 1'b1;
                        grant          <= winner;
                        cnt            <= '0;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (response_enable) begin
                        p_response_enable[grant] <= 1'b1;
                        p_data                   <= data;
                        last_grant               <= grant;
                        state                    <= IDLE;
                    end else if (timed_out) begin
                        p_response_enable[grant] <= 1'b1;
                        p_error[grant]           <= 1'b1;
                        p_data                   <= '0;
                        last_grant               <= grant;
                        state                    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected bus issues and port responses
// are queued as stimulus is driven and compared when the DUT pulses.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       p_request_enable = '0;
    logic [1:0]       p_mode = '0;
    logic [1:0][31:0] p_addr = '0;
    logic [1:0][31:0] p_wdata = '0;
    logic [1:0][3:0]  p_wstrb = '0;
    logic [1:0]       p_response_enable;
    logic [31:0]      p_data;
    logic [1:0]       p_error;
    logic             request_enable;
    logic             mode;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             response_enable = 1'b0;
    logic [31:0]      data = '0;
    logic             overflow;

    memreq_t exp_bus[$];
    resp_t   exp_resp[$];
    logic    ovf_exp = 1'b0;
    int      passed = 0;
    int      total  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .p_request_enable  (p_request_enable),
        .p_mode            (p_mode),
        .p_addr            (p_addr),
        .p_wdata           (p_wdata),
        .p_wstrb           (p_wstrb),
        .p_response_enable (p_response_enable),
        .p_data            (p_data),
        .p_error           (p_error),
        .request_enable    (request_enable),
        .mode              (mode),
        .addr              (addr),
        .wdata             (wdata),
        .wstrb             (wstrb),
        .response_enable   (response_enable),
        .data              (data),
        .overflow          (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        assert (got === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    endtask

    task automatic req(input int port, input logic m, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] s, input bit issue);
        p_request_enable[port] = 1'b1;
        p_mode[port]  = m;
        p_addr[port]  = a;
        p_wdata[port] = w;
        p_wstrb[port] = s;
        if (issue) exp_bus.push_back('{mode: m, addr: a, wdata: w, wstrb: s});
    endtask

    task automatic respond(input int port, input logic [31:0] d);
        response_enable = 1'b1;
        data = d;
        exp_resp.push_back('{port: port, data: d, err: 1'b0});
    endtask

    // Advance one edge, clear one-cycle pulses, then score whatever the DUT produced.
    task automatic tick();
        memreq_t e;
        resp_t   r;
        @(posedge clk);
        #1;
        p_request_enable = '0;
        response_enable  = 1'b0;
        if (request_enable) begin
            if (exp_bus.size() == 0) check("bus_unexpected", request_enable, 0);
            else begin
                e = exp_bus.pop_front();
                check("bus_mode",  mode,  e.mode);
                check("bus_addr",  addr,  e.addr);
                check("bus_wdata", wdata, e.wdata);
                check("bus_wstrb", wstrb, e.wstrb);
            end
        end
        if (p_response_enable != 2'b00) begin
            if (exp_resp.size() == 0) check("resp_unexpected", p_response_enable, 0);
            else begin
                r = exp_resp.pop_front();
                check("resp_port",  p_response_enable, 2'b01 << r.port);
                check("resp_error", p_error, r.err ? (2'b01 << r.port) : 2'b00);
                check("resp_data",  p_data, r.data);
            end
        end else begin
            check("error_idle", p_error, 0);
        end
        check("overflow", overflow, ovf_exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_req_en",  request_enable, 0);
        check("rst_resp_en", p_response_enable, 0);
        check("rst_error",   p_error, 0);
        check("rst_p_data",  p_data, 0);
        check("rst_mode",    mode, MEMREQ_READ);
        check("rst_addr",    addr, 0);
        check("rst_wdata",   wdata, 0);
        check("rst_wstrb",   wstrb, 0);
        check("rst_ovf",     overflow, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ovf_exp = 1'b0;
        ticks(2);
        check_reset_outputs();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_bus_left"},  exp_bus.size(), 0);
        check({tag, "_resp_left"}, exp_resp.size(), 0);
    endtask

    initial begin
        int cur;
        do_reset();

        // Single read from fetch.
        req(0, MEMREQ_READ, 32'h100, 32'h0, 4'h0, 1);
        tick();
        ticks(3);
        respond(0, 32'hDEADBEEF);
        ticks(2);
        check_drained("single");

        // Tie after reset: port 0 first, port 1 fields preserved.
        do_reset();
        req(0, MEMREQ_READ, 32'h300, 32'h0, 4'h0, 1);
        req(1, MEMREQ_WRITE, 32'h200, 32'h11223344, 4'b1111, 1);
        ticks(2);
        respond(0, 32'hA0A0A0A0);
        tick();
        tick();
        respond(1, 32'h0);
        ticks(2);
        // Second tie goes to port 0 again since port 1 was served last.
        req(0, MEMREQ_READ, 32'h304, 32'h0, 4'h0, 1);
        req(1, MEMREQ_READ, 32'h208, 32'h0, 4'h0, 1);
        ticks(2);
        respond(0, 32'h12345678);
        tick();
        tick();
        respond(1, 32'h87654321);
        ticks(2);
        check_drained("tie");

        // Round-robin with each port re-requesting as its response lands.
        req(0, MEMREQ_READ, 32'h1000, 32'h0, 4'h0, 1);
        req(1, MEMREQ_WRITE, 32'h2000, 32'hCAFE0001, 4'b0011, 1);
        tick();
        cur = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            respond(cur, 32'h5000 + n);
            if (n < 2) req(cur, MEMREQ_READ, 32'h3000 + 32'(n * 4), 32'h0, 4'h0, 1);
            tick();
            tick();
            cur ^= 1;
        end
        ticks(2);
        check_drained("rr");

        // Same-edge response and re-request from port 1.
        req(1, MEMREQ_READ, 32'h200, 32'h0, 4'h0, 1);
        ticks(2);
        respond(1, 32'hBEEF0200);
        req(1, MEMREQ_READ, 32'h204, 32'h0, 4'h0, 1);
        tick();
        tick();
        respond(1, 32'hBEEF0204);
        ticks(2);
        check_drained("same_edge");

        // Overflow: two extra pulses while port 1 is in flight are dropped.
        req(1, MEMREQ_WRITE, 32'h400, 32'h55AA55AA, 4'b1100, 1);
        tick();
        ovf_exp = 1'b1;
        req(1, MEMREQ_WRITE, 32'h404, 32'h0, 4'h0, 0);
        tick();
        req(1, MEMREQ_WRITE, 32'h408, 32'h0, 4'h0, 0);
        tick();
        respond(1, 32'h0);
        ticks(4);
        check_drained("overflow");

        // Timeout: forced error completion exactly 8 edges after the grant.
        do_reset();
        req(0, MEMREQ_READ, 32'h500, 32'h0, 4'h0, 1);
        tick();
        ticks(7);
        exp_resp.push_back('{port: 0, data: 32'h0, err: 1'b1});
        tick();
        ticks(3);
        response_enable = 1'b1;
        data = 32'hFFFF0000;
        ticks(3);
        check_drained("timeout");

        // Reset mid-transaction discards the in-flight and pending requests.
        req(1, MEMREQ_READ, 32'h600, 32'h0, 4'h0, 1);
        tick();
        req(0, MEMREQ_READ, 32'h604, 32'h0, 4'h0, 0);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b0;
        response_enable = 1'b1;
        data = 32'h0BADF00D;
        ticks(6);
        check_reset_outputs();
        check_drained("mid_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
